key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Conditions a raw board push-button, such as S1, for use by the LED and control logic.
- The flop-level path samples the button and drives the LED. This block is the opposite end of that path: it turns the noisy pad signal into a clean level, one-cycle press and release events, and a press-toggled LED output (LD1).
- It sits directly behind the key pad inputs, in the 50 MHz clk domain.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: number of consecutive stable clk cycles needed to accept a change (20 ms at 50 MHz). Must be ≥2. Benches use 8.
- KEY_ACTIVE_LOW, 1: 1 means a pressed key reads 0 on key_in; 0 means a pressed key reads 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES): counter width, derived; do not override.

Ports:
- clk  input  1  system clock, 50 MHz oscillator
- reset  input  1  asynchronous, active-low reset (RESET button)
- key_in  input  1  raw asynchronous key pad (S1)
- key_state  output  1  debounced level; 1 = pressed, independent of polarity
- key_press  output  1  one-clk pulse when a press is accepted
- key_release  output  1  one-clk pulse when a release is accepted
- led_toggle  output  1  inverts on every accepted press (LD1)

Behaviour:
- Reset: asynchronous and active-low. While reset=0:
  - key_state=0, key_press=0, key_release=0, led_toggle=0, counter=0, FSM=IDLE.
  - Both synchronizer flops load the released level (1 if KEY_ACTIVE_LOW, else 0), so releasing reset never generates a press.
- Synchronizer: two flops on key_in. Then normalise polarity: k = sync2 XOR KEY_ACTIVE_LOW, so k=1 means pressed.
- FSM states: IDLE (released, stable), PRESS_FILT, HELD (pressed, stable), RELEASE_FILT.
- IDLE:
  - k=1: go to PRESS_FILT, counter=1.
  - Else: stay, counter=0.
- PRESS_FILT:
  - k=0: return to IDLE, counter=0 (the glitch is discarded and no output changes).
  - k=1 and counter==DEBOUNCE_CYCLES-1: go to HELD; key_state<=1; key_press<=1 for exactly one cycle; led_toggle<=~led_toggle; counter=0.
  - Otherwise: counter+1.
- HELD: mirror of IDLE. k=0 goes to RELEASE_FILT with counter=1.
- RELEASE_FILT: mirror of PRESS_FILT.
  - k=1: return to HELD.
  - Completion: go to IDLE; key_state<=0; key_release<=1 for one cycle.
- Latency: a clean key_in edge reaches key_state and the pulse after 2 synchronizer cycles plus DEBOUNCE_CYCLES clk edges, ±1 cycle for input sampling phase. With DEBOUNCE_CYCLES=8 this is 10 or 11 edges.
- Counter:
  - Saturation is impossible by construction; it never exceeds DEBOUNCE_CYCLES-1.
  - Width CNT_W; the comparison is done at full width with no truncation.
- Pulse rules:
  - key_press and key_release are never both high.
  - Each is high for exactly one cycle per accepted transition.
  - There are no pulses during a filter abort.
- Bounce: any k change during filtering restarts filtering from the stable state. A bounce train therefore produces at most one accepted event, accepted only after the final stable interval.
- Held key: an indefinitely held key produces no further pulses. There is no auto-repeat.
- Reset mid-operation: asserting reset while in PRESS_FILT or HELD immediately clears all outputs, including led_toggle. After release from reset, a still-pressed key is accepted as a new press after the full debounce interval.
- Registers: all outputs are registered, with no combinational path from key_in.

Test Plan (DEBOUNCE_CYCLES=8, KEY_ACTIVE_LOW=1):
- Reset check: hold reset=0 for 5 cycles with key_in=1, then release. Required: all outputs 0 throughout and for 20 cycles after; no key_press.
- Clean press: drive key_in from 1 to 0 and hold. Required: key_press high for exactly 1 cycle, 10 or 11 edges after the change; key_state=1; led_toggle=1.
- Clean release: then drive key_in from 0 to 1. Required: key_release pulses once after 10 or 11 edges; key_state=0; led_toggle stays 1.
- Bounce: drive key_in low 3 cycles, high 2, low 5, high 1, then low and hold. Required: exactly one key_press, 10 or 11 edges after the final falling edge; no key_release.
- Short glitch: in HELD, pulse key_in high for 7 cycles. Required: key_state stays 1; no pulses. Second full press/release cycle: led_toggle returns to 0.
- Reset mid-filter: assert reset during PRESS_FILT, counter at 5, with the key still held. Required: outputs cleared asynchronously. After release, key_press arrives 10 or 11 edges later.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, polarity normalisation and a
// four-state debounce filter producing a clean level, press/release pulses and an LED toggle.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_in,
   output logic       key_state,
   output logic       key_press,
   output logic       key_release,
   output logic       led_toggle,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_FILT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_FILT = 2'd3
   } state_t;

   localparam logic             RELEASED_LVL = KEY_ACTIVE_LOW;
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic             k;
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             key_state_d;
   logic             key_press_d;
   logic             key_release_d;
   logic             led_toggle_d;

   // Synchronizer resets to the released level so leaving reset never looks like a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= RELEASED_LVL;
         sync2 <= RELEASED_LVL;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   assign k = sync2 ^ KEY_ACTIVE_LOW;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         key_state   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         led_toggle  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_state   <= key_state_d;
         key_press   <= key_press_d;
         key_release <= key_release_d;
         led_toggle  <= led_toggle_d;
      end
   end

   // Entering a filter state counts as the first stable cycle, hence counter=1 on entry.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      key_state_d   = key_state;
      key_press_d   = 1'b0;
      key_release_d = 1'b0;
      led_toggle_d  = led_toggle;
      case (state_q)
         IDLE: begin
            if (k) begin
               state_d = PRESS_FILT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         PRESS_FILT: begin
            if (!k) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = HELD;
               cnt_d        = '0;
               key_state_d  = 1'b1;
               key_press_d  = 1'b1;
               led_toggle_d = ~led_toggle;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!k) begin
               state_d = RELEASE_FILT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         RELEASE_FILT: begin
            if (k) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = IDLE;
               cnt_d         = '0;
               key_state_d   = 1'b0;
               key_release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign fsm_state = state_q;

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce; a run-length reference model
// predicts every accepted press/release and a negedge monitor scores the DUT.
module tb_key_debounce;

   localparam int DC = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_in;
   logic       key_state;
   logic       key_press;
   logic       key_release;
   logic       led_toggle;
   logic [1:0] fsm_state;

   always #10 clk = ~clk;

   key_debounce #(.DEBOUNCE_CYCLES(DC), .KEY_ACTIVE_LOW(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .led_toggle  (led_toggle),
      .fsm_state   (fsm_state)
   );

   // exp_q entry: bit 31 = 1 for press / 0 for release, bits 30:0 = clk edge number.
   logic [31:0] exp_q[$];

   int checks      = 0;
   int errors      = 0;
   int press_cnt   = 0;
   int release_cnt = 0;
   int last_ev_cyc = 0;

   // Reference model: a level is accepted once the synchronised key has differed
   // from the accepted level for DC consecutive edges.
   int cyc     = 0;
   bit d1      = 1'b1;
   bit d2      = 1'b1;
   bit m_state = 1'b0;
   bit m_led   = 1'b0;
   int run     = 0;
   bit mk;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         d1      = 1'b1;
         d2      = 1'b1;
         m_state = 1'b0;
         m_led   = 1'b0;
         run     = 0;
      end else begin
         cyc = cyc + 1;
         mk  = ~d2;
         d2  = d1;
         d1  = key_in;
         run = (mk != m_state) ? run + 1 : 0;
         if (run == DC) begin
            m_state = mk;
            run     = 0;
            if (mk) m_led = ~m_led;
            exp_q.push_back({mk, 31'(cyc)});
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic [31:0] e;
      checks++;
      if (key_state !== m_state) begin
         errors++;
         $display("FAIL key_state cyc=%0d got=%b exp=%b", cyc, key_state, m_state);
      end
      checks++;
      if (led_toggle !== m_led) begin
         errors++;
         $display("FAIL led_toggle cyc=%0d got=%b exp=%b", cyc, led_toggle, m_led);
      end
      if (key_press && key_release) begin
         errors++;
         $display("FAIL both_pulses cyc=%0d got=11 exp=not both", cyc);
      end
      if (key_press || key_release) begin
         if (key_press) press_cnt++;
         else release_cnt++;
         last_ev_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d got press=%b release=%b exp=none",
                     cyc, key_press, key_release);
         end else begin
            e = exp_q.pop_front();
            if (e[31] !== key_press || e[30:0] !== cyc[30:0]) begin
               errors++;
               $display("FAIL pulse cyc=%0d got press=%b exp press=%b at cyc=%0d",
                        cyc, key_press, e[31], e[30:0]);
            end
         end
      end else if (exp_q.size() > 0 && int'(exp_q[0][30:0]) < cyc) begin
         checks++;
         errors++;
         e = exp_q.pop_front();
         $display("FAIL missing_pulse cyc=%0d got none exp press=%b at cyc=%0d",
                  cyc, e[31], e[30:0]);
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic wait_ev(input bit want_press, input int t0, output int lat);
      int c0;
      c0  = want_press ? press_cnt : release_cnt;
      lat = -1;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if ((want_press ? press_cnt : release_cnt) != c0) begin
            lat = last_ev_cyc - t0;
            break;
         end
      end
   endtask

   task automatic chk_lat(input string name, input int lat);
      checks++;
      if (lat < 10 || lat > 11) begin
         errors++;
         $display("FAIL %s latency got=%0d exp=10..11", name, lat);
      end
   endtask

   function automatic int outs();
      return {28'd0, key_state, key_press, key_release, led_toggle};
   endfunction

   initial begin : stim
      int lat;
      int t0;
      int p0;
      int r0;
      int lvl;

      // Reset held with key released
      reset  = 1'b0;
      key_in = 1'b1;
      step(5);
      chk("reset_outs", outs(), 0);
      reset = 1'b1;
      step(20);
      chk("post_reset_outs", outs(), 0);
      chk("post_reset_press", press_cnt, 0);

      // Clean press
      t0 = cyc;
      key_in = 1'b0;
      wait_ev(1'b1, t0, lat);
      chk_lat("clean_press", lat);
      step(3);
      chk("clean_press_cnt", press_cnt, 1);
      chk("clean_press_state", key_state, 1);
      chk("clean_press_led", led_toggle, 1);

      // Clean release
      t0 = cyc;
      key_in = 1'b1;
      wait_ev(1'b0, t0, lat);
      chk_lat("clean_release", lat);
      step(3);
      chk("clean_release_cnt", release_cnt, 1);
      chk("clean_release_state", key_state, 0);
      chk("clean_release_led", led_toggle, 1);

      // Bounce train
      p0 = press_cnt;
      r0 = release_cnt;
      key_in = 1'b0; step(3);
      key_in = 1'b1; step(2);
      key_in = 1'b0; step(5);
      key_in = 1'b1; step(1);
      t0 = cyc;
      key_in = 1'b0;
      wait_ev(1'b1, t0, lat);
      chk_lat("bounce_press", lat);
      step(10);
      chk("bounce_press_cnt", press_cnt, p0 + 1);
      chk("bounce_release_cnt", release_cnt, r0);
      chk("bounce_led", led_toggle, 0);

      // Short glitch while held
      p0 = press_cnt;
      r0 = release_cnt;
      key_in = 1'b1; step(7);
      key_in = 1'b0; step(20);
      chk("glitch_state", key_state, 1);
      chk("glitch_press_cnt", press_cnt, p0);
      chk("glitch_release_cnt", release_cnt, r0);

      // Release, then press again into HELD with led set
      t0 = cyc;
      key_in = 1'b1;
      wait_ev(1'b0, t0, lat);
      chk_lat("second_release", lat);
      step(5);
      t0 = cyc;
      key_in = 1'b0;
      wait_ev(1'b1, t0, lat);
      chk_lat("third_press", lat);
      step(3);
      chk("held_led", led_toggle, 1);

      // Reset in HELD clears everything at once
      reset = 1'b0;
      #1;
      chk("reset_held_outs", outs(), 0);
      step(3);
      t0 = cyc;
      reset = 1'b1;
      wait_ev(1'b1, t0, lat);
      chk_lat("press_after_held_reset", lat);
      step(3);
      chk("press_after_held_reset_led", led_toggle, 1);

      // Reset in PRESS_FILT with counter at 5
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      p0 = press_cnt;
      step(7);
      chk("mid_filter_no_press", press_cnt, p0);
      reset = 1'b0;
      #1;
      chk("reset_filter_outs", outs(), 0);
      step(2);
      t0 = cyc;
      reset = 1'b1;
      wait_ev(1'b1, t0, lat);
      chk_lat("press_after_filter_reset", lat);
      t0 = cyc;
      key_in = 1'b1;
      wait_ev(1'b0, t0, lat);
      chk_lat("final_release", lat);

      // Randomised hold lengths around the debounce threshold
      lvl = 1;
      for (int s = 0; s < 60; s++) begin
         lvl = (($urandom_range(0, 3) == 0) ? lvl : 1 - lvl);
         key_in = lvl[0];
         step($urandom_range(1, 14));
      end
      key_in = 1'b1;
      step(30);
      chk("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
